// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its buffer.
package instr_fetch_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    // Byte addresses of instructions are always word aligned.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Bundle of control, program-memory and decode-side signals of the fetch unit.
interface instr_fetch_if;
    import instr_fetch_pkg::*;

    logic               fetch_en;
    logic               redirect_valid;
    logic [XLEN-1:0]    redirect_pc;
    logic [XLEN-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [XLEN-1:0]    out_pc;

    modport master (
        input  fetch_en, redirect_valid, redirect_pc, imem_data, out_ready,
        output imem_addr, out_valid, out_instr, out_pc
    );

    modport slave (
        output fetch_en, redirect_valid, redirect_pc, imem_data, out_ready,
        input  imem_addr, out_valid, out_instr, out_pc
    );
endinterface

// File: rtl/instr_fetch_fifo.sv
// Instruction buffer: DEPTH entries of {pc, instr} with wrapping pointers and flush.
module fetch_fifo
    import instr_fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               push,
    input  logic [XLEN-1:0]    push_pc,
    input  logic [INSTR_W-1:0] push_instr,
    input  logic               pop,
    output logic [CNT_W-1:0]   count,
    output logic               empty,
    output logic               full,
    output logic [XLEN-1:0]    head_pc,
    output logic [INSTR_W-1:0] head_instr
);

    logic [XLEN-1:0]    pc_mem    [DEPTH];
    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else if (push && !flush) begin
            pc_mem[wr_ptr_reg]    <= push_pc;
            instr_mem[wr_ptr_reg] <= push_instr;
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign count      = count_reg;
    assign empty      = (count_reg == '0);
    assign full       = (count_reg == CNT_W'(DEPTH));
    assign head_pc    = pc_mem[rd_ptr_reg];
    assign head_instr = instr_mem[rd_ptr_reg];

endmodule

// File: rtl/instr_fetch.sv
// Fetch unit: pc register, IDLE/RUN control and redirect handling in front of the buffer.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_fetch_if.master      bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_t       state_reg;
    logic [XLEN-1:0]    pc_reg;
    logic               push;
    logic               pop;
    logic               empty;
    logic               full;
    logic [CNT_W-1:0]   count;

    // Redirect wins: no pop and no push in a redirect cycle.
    assign pop  = !empty && bus.out_ready && !bus.redirect_valid;
    assign push = (state_reg == RUN) && bus.fetch_en && !bus.redirect_valid
                  && (!full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            pc_reg    <= word_align(RESET_PC);
        end else begin
            case (state_reg)
                IDLE:    if (bus.fetch_en)  state_reg <= RUN;
                RUN:     if (!bus.fetch_en) state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
            if (bus.redirect_valid)
                pc_reg <= word_align(bus.redirect_pc);
            else if (push)
                pc_reg <= pc_reg + XLEN'(4);
        end
    end

    assign bus.imem_addr = {2'b00, pc_reg[XLEN-1:2]};

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (bus.redirect_valid),
        .push       (push),
        .push_pc    (pc_reg),
        .push_instr (bus.imem_data),
        .pop        (pop),
        .count      (count),
        .empty      (empty),
        .full       (full),
        .head_pc    (bus.out_pc),
        .head_instr (bus.out_instr)
    );

    assign bus.out_valid = (count != '0);

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: queue-based reference model plus directed literal checks.
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    instr_fetch_if bus ();

    instr_fetch #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Program memory: word i holds 32'h1000_0000 + i (low 28 address bits).
    function automatic logic [31:0] mem_word(input logic [31:0] word_addr);
        return 32'h1000_0000 + (word_addr & 32'h0FFF_FFFF);
    endfunction

    always_comb bus.imem_data = mem_word(bus.imem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of fetched {pc, instr}, byte pc, and whether fetching is active.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t      mq[$];
    logic [31:0] m_pc  = RESET_PC & ~32'h3;
    bit          m_run = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_pc  = RESET_PC & ~32'h3;
            m_run = 1'b0;
        end else begin
            if (bus.redirect_valid) begin
                mq.delete();
                m_pc = bus.redirect_pc & ~32'h3;
            end else begin
                bit do_pop;
                bit do_push;
                entry_t e;
                do_pop  = (mq.size() > 0) && bus.out_ready;
                do_push = m_run && bus.fetch_en && ((mq.size() < DEPTH) || do_pop);
                if (do_pop) void'(mq.pop_front());
                if (do_push) begin
                    e.pc    = m_pc;
                    e.instr = mem_word(m_pc >> 2);
                    mq.push_back(e);
                    m_pc = m_pc + 32'd4;
                end
            end
            m_run = bus.fetch_en;
        end
    end

    always @(negedge clk) begin
        check("model_out_valid", {31'b0, bus.out_valid}, {31'b0, mq.size() != 0});
        check("model_imem_addr", bus.imem_addr, m_pc >> 2);
        if (mq.size() != 0) begin
            check("model_out_pc", bus.out_pc, mq[0].pc);
            check("model_out_instr", bus.out_instr, mq[0].instr);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] ready_pat;

    initial begin
        rst_n              = 1'b0;
        bus.fetch_en       = 1'b0;
        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        #2;
        check("rst_valid", {31'b0, bus.out_valid}, 32'h0);
        check("rst_pc", bus.out_pc, 32'h0);
        check("rst_instr", bus.out_instr, 32'h0);
        check("rst_imem_addr", bus.imem_addr, RESET_PC >> 2);
        tick(); tick();

        // Straight-line stream after reset release.
        rst_n = 1'b1; bus.fetch_en = 1'b1; bus.out_ready = 1'b1;
        tick();
        check("start_latency_valid", {31'b0, bus.out_valid}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stream_pc", bus.out_pc, 32'(i * 4));
            check("stream_instr", bus.out_instr, 32'h1000_0000 + 32'(i));
        end

        // Back-pressure: restart at 0, hold out_ready low until the buffer fills.
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0; bus.out_ready = 1'b0;
        tick();
        bus.redirect_valid = 1'b0;
        repeat (5) tick();
        check("full_valid", {31'b0, bus.out_valid}, 32'h1);
        check("full_pc", bus.out_pc, 32'h0);
        check("full_imem_addr", bus.imem_addr, 32'h2);
        bus.out_ready = 1'b1;
        tick();
        check("drain_pc4", bus.out_pc, 32'h4);
        tick();
        check("drain_pc8", bus.out_pc, 32'h8);

        // Redirect while full with out_ready high.
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0016;
        tick();
        check("redir_flush_valid", {31'b0, bus.out_valid}, 32'h0);
        check("redir_imem_addr", bus.imem_addr, 32'h5);
        bus.redirect_valid = 1'b0;
        tick();
        check("redir_pc", bus.out_pc, 32'h0000_0014);
        check("redir_instr", bus.out_instr, 32'h1000_0005);

        // Stop fetching with one entry buffered, drain, then resume.
        bus.fetch_en = 1'b0; bus.out_ready = 1'b0;
        tick();
        check("idle_hold_pc", bus.out_pc, 32'h0000_0014);
        check("idle_hold_addr", bus.imem_addr, 32'h6);
        bus.out_ready = 1'b1;
        tick();
        check("idle_drain_valid", {31'b0, bus.out_valid}, 32'h0);
        tick();
        check("idle_pc_kept", bus.imem_addr, 32'h6);
        bus.fetch_en = 1'b1;
        tick();
        check("resume_gap_valid", {31'b0, bus.out_valid}, 32'h0);
        tick();
        check("resume_pc", bus.out_pc, 32'h0000_0018);
        check("resume_instr", bus.out_instr, 32'h1000_0006);

        // Redirect while idle, unaligned target.
        bus.fetch_en = 1'b0; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0041;
        tick();
        check("idle_redir_addr", bus.imem_addr, 32'h10);
        bus.redirect_valid = 1'b0;
        tick();
        check("idle_redir_valid", {31'b0, bus.out_valid}, 32'h0);
        bus.fetch_en = 1'b1;
        tick(); tick();
        check("idle_redir_pc", bus.out_pc, 32'h0000_0040);

        // pc wrap at the top of the address space.
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFFF;
        tick();
        check("wrap_top_addr", bus.imem_addr, 32'h3FFF_FFFF);
        bus.redirect_valid = 1'b0;
        tick();
        check("wrap_pc_top", bus.out_pc, 32'hFFFF_FFFC);
        check("wrap_instr_top", bus.out_instr, 32'h1FFF_FFFF);
        check("wrap_addr_zero", bus.imem_addr, 32'h0);
        tick();
        check("wrap_pc_zero", bus.out_pc, 32'h0);

        // Short reset pulse in the middle of a stream.
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("pulse_valid", {31'b0, bus.out_valid}, 32'h0);
        check("pulse_pc", bus.out_pc, 32'h0);
        check("pulse_imem_addr", bus.imem_addr, RESET_PC >> 2);
        #4;
        rst_n = 1'b1;
        tick(); tick();
        check("pulse_first_pc", bus.out_pc, RESET_PC);

        // Irregular back-pressure, checked by the model each cycle.
        ready_pat = 16'b1011_0010_1110_0101;
        for (int i = 0; i < 16; i++) begin
            bus.out_ready = ready_pat[i];
            tick();
        end
        bus.out_ready = 1'b1;
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
